// File: rtl/ntt_stage_ctrl_pkg.sv
// Shared types and address arithmetic for the NTT stage sequencer.
package ntt_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ctrl_state_e;

  function automatic int calc_la(input int log_n, input int log_core);
    return log_n - log_core - 1;
  endfunction

  function automatic int calc_loops(input int la);
    return 1 << la;
  endfunction

  // Inter-word stages index a growing twiddle table; intra-word stages use their own bank.
  function automatic int unsigned tw_addr(input int unsigned s, input int unsigned c,
                                          input int unsigned la);
    if (s >= la) return c;
    return ((32'd1 << s) - 32'd1) + (c >> (la - s));
  endfunction

endpackage

// File: rtl/ntt_stage_ctrl_if.sv
// Handshake and address bus between the NTT stage sequencer and its datapath.
// NTT_CTRL_DEBUG_EN adds the observation signals dbg_loop/dbg_stage/dbg_stall_cnt.
interface ntt_stage_ctrl_if #(parameter int LA = 8);
  logic          start;
  logic          mode;
  logic          stall;
  logic          busy;
  logic          rd_en;
  logic [LA-1:0] raddr;
  logic [LA:0]   raddr_tw;
  logic          tw_inv;
  logic          eo_signal;
  logic          type_signal;
  logic          wr_en;
  logic [LA-1:0] waddr;
  logic          finished;
`ifdef NTT_CTRL_DEBUG_EN
  logic [LA-1:0] dbg_loop;
  logic [4:0]    dbg_stage;
  logic [15:0]   dbg_stall_cnt;

  modport master (
    input  start, mode, stall,
    output busy, rd_en, raddr, raddr_tw, tw_inv, eo_signal, type_signal,
           wr_en, waddr, finished, dbg_loop, dbg_stage, dbg_stall_cnt
  );
  modport slave (
    output start, mode, stall,
    input  busy, rd_en, raddr, raddr_tw, tw_inv, eo_signal, type_signal,
           wr_en, waddr, finished, dbg_loop, dbg_stage, dbg_stall_cnt
  );
`else
  modport master (
    input  start, mode, stall,
    output busy, rd_en, raddr, raddr_tw, tw_inv, eo_signal, type_signal,
           wr_en, waddr, finished
  );
  modport slave (
    output start, mode, stall,
    input  busy, rd_en, raddr, raddr_tw, tw_inv, eo_signal, type_signal,
           wr_en, waddr, finished
  );
`endif
endinterface

// File: rtl/ntt_addr_delay.sv
// Stall-gated delay line matching the butterfly pipeline: carries read valid/address to the write side.
module ntt_addr_delay #(
  parameter int AW    = 8,
  parameter int DEPTH = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          in_vld,
  input  logic [AW-1:0] in_addr,
  output logic          out_vld,
  output logic [AW-1:0] out_addr
);

  logic          vld_p  [DEPTH];
  logic [AW-1:0] addr_p [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_p[i]  <= 1'b0;
        addr_p[i] <= '0;
      end
    end else if (!stall) begin
      vld_p[0]  <= in_vld;
      addr_p[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i]  <= vld_p[i-1];
        addr_p[i] <= addr_p[i-1];
      end
    end
  end

  assign out_vld  = vld_p[DEPTH-1];
  assign out_addr = addr_p[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// Pass/loop sequencer for the iterative NTT/INTT butterfly datapath over ping-pong banks.
// Optional NTT_CTRL_DEBUG_EN exposes loop, stage and a saturating stall counter.
module ntt_stage_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int LOG_N    = 12,
  parameter int LOG_CORE = 3,
  parameter int PIPE_LAT = 6
) (
  input logic               clk,
  input logic               reset,
  ntt_stage_ctrl_if.master  bus
);

  localparam int LA    = calc_la(LOG_N, LOG_CORE);
  localparam int TW_W  = LA + 1;
  localparam int TMR_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  ctrl_state_e      state, state_nxt;
  logic [LA-1:0]    c_loop, c_loop_nxt;
  logic [4:0]       pass, pass_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             mode_q, mode_nxt;
  logic             start_acc;
  logic [4:0]       stage;
  logic             dly_vld;
  logic [LA-1:0]    dly_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      c_loop <= '0;
      pass   <= '0;
      tmr    <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      c_loop <= c_loop_nxt;
      pass   <= pass_nxt;
      tmr    <= tmr_nxt;
      mode_q <= mode_nxt;
    end
  end

  // A stall freezes every state and counter; the pass index only advances when a gap ends.
  always_comb begin
    state_nxt  = state;
    c_loop_nxt = c_loop;
    pass_nxt   = pass;
    tmr_nxt    = tmr;
    mode_nxt   = mode_q;
    start_acc  = 1'b0;
    if (!bus.stall) begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state_nxt  = RUN;
            c_loop_nxt = '0;
            pass_nxt   = '0;
            tmr_nxt    = '0;
            mode_nxt   = bus.mode;
            start_acc  = 1'b1;
          end
        end
        RUN: begin
          if (&c_loop) begin
            c_loop_nxt = '0;
            tmr_nxt    = '0;
            state_nxt  = (pass == 5'(LOG_N - 1)) ? DRAIN : GAP;
          end else begin
            c_loop_nxt = c_loop + 1'b1;
          end
        end
        GAP: begin
          if (tmr == TMR_W'(PIPE_LAT - 1)) begin
            tmr_nxt   = '0;
            pass_nxt  = pass + 5'd1;
            state_nxt = RUN;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
        DRAIN: begin
          if (tmr == TMR_W'(PIPE_LAT - 1)) begin
            tmr_nxt   = '0;
            state_nxt = DONE;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign stage = mode_q ? (5'(LOG_N - 1) - pass) : pass;

  assign bus.busy        = (state != IDLE);
  assign bus.rd_en       = (state == RUN) && !bus.stall;
  assign bus.raddr       = c_loop;
  assign bus.raddr_tw    = TW_W'(tw_addr(32'(stage), 32'(c_loop), LA));
  assign bus.tw_inv      = mode_q;
  assign bus.eo_signal   = pass[0];
  assign bus.type_signal = (stage >= 5'(LA));
  assign bus.finished    = (state == DONE);
  assign bus.wr_en       = dly_vld && !bus.stall;
  assign bus.waddr       = dly_addr;

  // Read side -> write side, PIPE_LAT un-stalled cycles later.
  ntt_addr_delay #(
    .AW    (LA),
    .DEPTH (PIPE_LAT)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .stall    (bus.stall),
    .in_vld   (bus.rd_en),
    .in_addr  (c_loop),
    .out_vld  (dly_vld),
    .out_addr (dly_addr)
  );

`ifdef NTT_CTRL_DEBUG_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (bus.stall && (state != IDLE) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.dbg_loop      = c_loop;
  assign bus.dbg_stage     = stage;
  assign bus.dbg_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Self-checking bench for ntt_stage_ctrl: timeline reference model derived from pass/loop arithmetic.
module tb_ntt_stage_ctrl;

  localparam int LOG_N    = 5;
  localparam int LOG_CORE = 1;
  localparam int P        = 2;
  localparam int LA       = LOG_N - LOG_CORE - 1;
  localparam int L        = 2 ** LA;
  localparam int BLK      = L + P;
  localparam int T        = LOG_N * BLK + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ntt_stage_ctrl_if #(.LA(LA)) bus ();

  ntt_stage_ctrl #(
    .LOG_N    (LOG_N),
    .LOG_CORE (LOG_CORE),
    .PIPE_LAT (P)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] outs_flat;
  assign outs_flat = {15'd0, bus.busy, bus.rd_en, bus.raddr, bus.raddr_tw, bus.tw_inv,
                      bus.eo_signal, bus.type_signal, bus.wr_en, bus.waddr, bus.finished};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Position k counts un-stalled cycles since start was sampled (k=1 is the first busy cycle).
  function automatic int pass_of(input int k);
    int p;
    if (k < 1) return 0;
    p = (k - 1) / BLK;
    return (p > LOG_N - 1) ? LOG_N - 1 : p;
  endfunction

  function automatic int off_of(input int k);
    return k - 1 - pass_of(k) * BLK;
  endfunction

  function automatic bit is_read(input int k);
    if (k < 1 || k > T - 1) return 1'b0;
    return off_of(k) < L;
  endfunction

  function automatic int stage_of(input int k, input bit m);
    return m ? (LOG_N - 1 - pass_of(k)) : pass_of(k);
  endfunction

  function automatic int tw_ref(input int s, input int c);
    if (s >= LA) return c;
    return (2 ** s - 1) + c / (2 ** (LA - s));
  endfunction

  task automatic check_cycle(input int k, input bit st, input bit m);
    int s;
    check($sformatf("busy@k%0d", k), bus.busy, (k >= 1 && k <= T));
    check($sformatf("finished@k%0d", k), bus.finished, (k == T));
    check($sformatf("rd_en@k%0d", k), bus.rd_en, is_read(k) && !st);
    check($sformatf("wr_en@k%0d", k), bus.wr_en, is_read(k - P) && !st);
    if (is_read(k - P)) check($sformatf("waddr@k%0d", k), bus.waddr, off_of(k - P));
    check($sformatf("eo@k%0d", k), bus.eo_signal, pass_of(k) % 2);
    check($sformatf("tw_inv@k%0d", k), bus.tw_inv, m);
    if (is_read(k)) begin
      s = stage_of(k, m);
      check($sformatf("raddr@k%0d", k), bus.raddr, off_of(k));
      check($sformatf("type@k%0d", k), bus.type_signal, (s >= LA));
      check($sformatf("raddr_tw@k%0d", k), bus.raddr_tw, tw_ref(s, off_of(k)));
    end
  endtask

  // stall_mode: 0 none, 1 five cycles at pass 1 loop 3, 2 random. abort_k>0 resets at that position.
  task automatic do_run(input bit m, input int stall_mode, input int abort_k, input int exp_fin);
    int k, cyc, nstall, fin_cyc;
    bit st;
    k = 0; cyc = 0; nstall = 0; fin_cyc = -1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = m; bus.stall = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    @(posedge clk);
    k = 1;
    while (k <= T && cyc < 1000) begin
      #1;
      cyc++;
      bus.start = 1'($urandom_range(0, 1));
      bus.mode  = 1'($urandom_range(0, 1));
      st = 1'b0;
      if (stall_mode == 1 && k == BLK + 3 + 1 && nstall < 5) st = 1'b1;
      if (stall_mode == 2 && k < T && $urandom_range(0, 3) == 0) st = 1'b1;
      bus.stall = st;
      if (k == abort_k) begin
        reset = 1'b0;
        #1;
        check("abort_outs_zero", outs_flat, 0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("abort_finished", bus.finished, 0);
          check("abort_busy", bus.busy, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1; bus.start = 1'b0; bus.stall = 1'b0;
        return;
      end
      @(negedge clk);
      check_cycle(k, st, m);
      if (bus.finished === 1'b1 && fin_cyc < 0) fin_cyc = cyc;
      @(posedge clk);
      if (st) nstall++;
      else k++;
    end
    #1;
    bus.start = 1'b0; bus.stall = 1'b0;
    check("run_bound", k, T + 1);
    check("finish_cycle", fin_cyc, (stall_mode == 2) ? T + nstall : exp_fin);
    @(negedge clk);
    check("post_busy", bus.busy, 0);
    check("post_finished", bus.finished, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("still_idle", bus.busy, 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs_zero", outs_flat, 0);
    reset = 1'b1;

    do_run(1'b0, 0, 0, 51);
    do_run(1'b1, 0, 0, 51);
    do_run(1'b0, 1, 0, 56);
    do_run(1'b1, 0, 2 * BLK + 5 + 1, 0);
    do_run(1'b0, 0, 0, 51);
    repeat (3) do_run(1'($urandom_range(0, 1)), 2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
Parametrised sequencer for the iterative NTT/INTT datapath of NTT_CORE butterfly lanes over ping-pong coefficient memories. It generates per-stage read addresses, twiddle ROM addresses, bank/type selects and a latency-matched write stream. It adds forward/inverse mode, a stall input, inter-stage hazard gaps and a start/busy/finished handshake.

Parameters:
LOG_N, 12, log2 ring size; stage count = LOG_N
LOG_CORE, 3, log2 butterfly lanes
PIPE_LAT, 6, read-to-write latency of the butterfly pipeline in cycles (>=1)
Derived: LA = LOG_N-LOG_CORE-1 (address width), L = 2^LA loops per stage

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
mode  in  1  0 = forward NTT, 1 = inverse; latched at accepted start
stall  in  1  freezes the controller and the write delay line
busy  out  1  high from the cycle after start is accepted until finished
rd_en  out  1  read address valid
raddr  out  LA  coefficient read address (= c_loop)
raddr_tw  out  LA+1  twiddle ROM address
tw_inv  out  1  selects inverse twiddle ROM (= latched mode)
eo_signal  out  1  ping-pong bank select for the current stage
type_signal  out  1  0 = inter-word stage, 1 = intra-word (shuffle) stage
wr_en  out  1  rd_en delayed by PIPE_LAT un-stalled cycles
waddr  out  LA  raddr delayed identically
finished  out  1  one-cycle pulse at completion

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; delay line cleared. Reset mid-operation aborts immediately with no finished pulse.
- States: IDLE -> RUN on start. RUN -> GAP at the last loop of a non-final pass. GAP -> RUN after PIPE_LAT cycles. RUN -> DRAIN at the last loop of the final pass. DRAIN -> DONE after PIPE_LAT cycles. DONE -> IDLE.
- finished is high for exactly the DONE cycle. start during busy or DONE is ignored.
- Pass counter p runs 0..LOG_N-1. Logical stage s = p in forward mode and s = LOG_N-1-p in inverse mode. c_loop runs 0..L-1 within each pass.
- rd_en is 1 only in RUN with stall=0. raddr = c_loop.
- eo_signal = p[0]; it flips on entry to each new pass and is constant through GAP.
- type_signal = 1 iff s >= LA.
- raddr_tw, type 0: (2^s - 1) + (c_loop >> (LA - s)), computed in LA+1 bits; no overflow is possible.
- raddr_tw, type 1: {1'b0, c_loop}, addressing the separate intra-word bank.
- stall=1: state, c_loop, p and GAP/DRAIN timers hold; rd_en is 0; other outputs hold their values. The delay line does not shift, and wr_en is forced 0 while stalled.
- Latency: the first rd_en occurs the cycle after start is sampled. Each write appears PIPE_LAT un-stalled cycles after its read.
- Total un-stalled cycles from start sample to finished = LOG_N*L + (LOG_N-1)*PIPE_LAT + PIPE_LAT + 1.

Optional Feature:
NTT_CTRL_DEBUG_EN:
- Defined: adds output ports dbg_loop (LA) = c_loop, dbg_stage (5) = s, and dbg_stall_cnt (16), a saturating count of stalled cycles while busy, cleared on accepted start.
- Undefined: these ports and their counter are absent. Functional behaviour is identical either way.

Decomposition:
- Package ntt_ctrl_pkg: state enum (IDLE, RUN, GAP, DRAIN, DONE), the LA/L width helper functions and the twiddle-address function.
- One sub-module, ntt_addr_delay: a PIPE_LAT-deep, stall-gated shift register carrying {rd_en, raddr}.

Test Plan:
- Forward run, LOG_N=5, LOG_CORE=1, PIPE_LAT=2, no stall: 40 rd_en cycles, 8 gap cycles, finished in cycle 51 after start; busy low the cycle after.
- Same run, addresses: pass 0 raddr_tw = 0 for every loop; pass 2 raddr_tw = 3 + (c_loop>>1), i.e. 3,3,4,4,5,5,6,6; type_signal = 1 only on passes 3-4; eo_signal sequence 0,1,0,1,0.
- Inverse run, same parameters: s sequence 4,3,2,1,0; tw_inv = 1; type_signal = 1 on passes 0-1; total cycle count still 51.
- Stall for 5 cycles at loop 3 of pass 1: raddr holds at 3, rd_en=0, wr_en=0; finished arrives at cycle 56; the waddr stream equals the raddr stream with no gaps or duplicates.
- start pulsed while busy, and a second start in the DONE cycle: both ignored; next start after IDLE begins a fresh run with eo_signal=0.
- reset asserted at loop 5 of pass 2: all outputs 0 asynchronously, no finished pulse; a subsequent start completes normally in 51 cycles.
